// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared constants for the CO224 8-bit single-cycle execution core:
//   - opcode encodings (OP_LOADI .. OP_SWI)
//   - ALU operation selects (ALU_FWD / ALU_ADD / ALU_AND / ALU_OR)
//   - PC_RESET, the address held in the PC while the core is in reset
//   - ctrl_t, the bundle of decoded control signals
// ---------------------------------------------------------------------------
package cpu_pkg;

    localparam logic [7:0] OP_LOADI = 8'h00;
    localparam logic [7:0] OP_MOV   = 8'h01;
    localparam logic [7:0] OP_ADD   = 8'h02;
    localparam logic [7:0] OP_SUB   = 8'h03;
    localparam logic [7:0] OP_AND   = 8'h04;
    localparam logic [7:0] OP_OR    = 8'h05;
    localparam logic [7:0] OP_J     = 8'h06;
    localparam logic [7:0] OP_BEQ   = 8'h07;
    localparam logic [7:0] OP_LWD   = 8'h08;
    localparam logic [7:0] OP_LWI   = 8'h09;
    localparam logic [7:0] OP_SWD   = 8'h0A;
    localparam logic [7:0] OP_SWI   = 8'h0B;

    localparam logic [2:0] ALU_FWD  = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;

    // Chosen so that PC + 4 is address 0 on the first fetch after reset.
    localparam logic [31:0] PC_RESET = 32'hFFFF_FFFC;

    typedef struct packed {
        logic       we;
        logic [2:0] aluop;
        logic       alusrc;
        logic       neg;
        logic       branch;
        logic       mrd;
        logic       mwr;
        logic       memtoreg;
    } ctrl_t;

endpackage

// File: rtl/cpu_exec_alu.sv
// ---------------------------------------------------------------------------
// cpu_exec_alu
// Combinational 8-bit ALU of the CO224 core.
//   a      in  8  operand A (register src1)
//   b      in  8  operand B (already negated / immediate-selected)
//   sel    in  3  operation select (ALU_* constants)
//   result out 8  ALU result, wraps modulo 256
//   zero   out 1  result == 0
// ---------------------------------------------------------------------------
module cpu_exec_alu
    import cpu_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [2:0] sel,
    output logic [7:0] result,
    output logic       zero
);

    // Encodings with sel[2] set are unused and return 0.
    always_comb begin
        result = 8'h00;
        case (sel)
            ALU_FWD: result = b;
            ALU_ADD: result = a + b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            default: result = 8'h00;
        endcase
    end

    assign zero = (result == 8'h00);

endmodule

// File: rtl/cpu_exec_core.sv
// ---------------------------------------------------------------------------
// cpu_exec_core
// Single-cycle datapath of the 8-bit CO224 processor: PC register, decoder,
// operand muxes, ALU and next-PC selection. Register file and data memory
// are external.
//   CLK          in   1  rising-edge clock
//   RESET        in   1  asynchronous active-high reset
//   BUSYWAIT     in   1  data-memory stall; freezes PC and register writes
//   INSTRUCTION  in  32  opcode[31:24] dest/off[23:16] src1[15:8] src2/imm[7:0]
//   REGOUT1/2    in   8  register-file read data
//   READDATA     in   8  data-memory read data
//   PC           out 32  instruction address
//   READREG1/2   out  3  register-file read addresses
//   WRITEREG     out  3  register-file write address
//   REGWRITE     out  1  register-file write enable
//   WRITEBACK    out  8  register write data
//   ALURESULT    out  8  ALU result / data-memory address
//   WRITEDATA    out  8  store data
//   MEMREAD      out  1  data-memory read request
//   MEMWRITE     out  1  data-memory write request
//   ZERO         out  1  ALURESULT == 0
// ---------------------------------------------------------------------------
module cpu_exec_core #(
    parameter logic [31:0] PC_RESET = cpu_pkg::PC_RESET
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        BUSYWAIT,
    input  logic [31:0] INSTRUCTION,
    input  logic [7:0]  REGOUT1,
    input  logic [7:0]  REGOUT2,
    input  logic [7:0]  READDATA,
    output logic [31:0] PC,
    output logic [2:0]  READREG1,
    output logic [2:0]  READREG2,
    output logic [2:0]  WRITEREG,
    output logic        REGWRITE,
    output logic [7:0]  WRITEBACK,
    output logic [7:0]  ALURESULT,
    output logic [7:0]  WRITEDATA,
    output logic        MEMREAD,
    output logic        MEMWRITE,
    output logic        ZERO
);

    import cpu_pkg::*;

    ctrl_t       ctrl;
    logic [7:0]  opcode;
    logic [7:0]  offset;
    logic [7:0]  imm;
    logic [7:0]  opb;
    logic [7:0]  alu_b;
    logic [31:0] pc4;
    logic [31:0] target;
    logic        taken;
    logic [31:0] next_pc;
    logic        pc_valid;
    logic        unused_ok;

    assign opcode    = INSTRUCTION[31:24];
    assign offset    = INSTRUCTION[23:16];
    assign imm       = INSTRUCTION[7:0];
    assign READREG1  = INSTRUCTION[10:8];
    assign READREG2  = INSTRUCTION[2:0];
    assign WRITEREG  = INSTRUCTION[18:16];
    assign WRITEDATA = REGOUT1;

    assign unused_ok = &{1'b0, INSTRUCTION[15:11]};

    // Decoder: unknown opcodes leave every control low and act as a NOP.
    always_comb begin
        ctrl = '0;
        case (opcode)
            OP_LOADI: begin ctrl.we = 1'b1; ctrl.aluop = ALU_FWD; ctrl.alusrc = 1'b1; end
            OP_MOV:   begin ctrl.we = 1'b1; ctrl.aluop = ALU_FWD; end
            OP_ADD:   begin ctrl.we = 1'b1; ctrl.aluop = ALU_ADD; end
            OP_SUB:   begin ctrl.we = 1'b1; ctrl.aluop = ALU_ADD; ctrl.neg = 1'b1; end
            OP_AND:   begin ctrl.we = 1'b1; ctrl.aluop = ALU_AND; end
            OP_OR:    begin ctrl.we = 1'b1; ctrl.aluop = ALU_OR; end
            OP_J:     begin ctrl.branch = 1'b1; end
            OP_BEQ:   begin ctrl.branch = 1'b1; ctrl.aluop = ALU_ADD; ctrl.neg = 1'b1; end
            OP_LWD:   begin ctrl.we = 1'b1; ctrl.aluop = ALU_FWD; ctrl.mrd = 1'b1; ctrl.memtoreg = 1'b1; end
            OP_LWI:   begin
                ctrl.we = 1'b1; ctrl.aluop = ALU_FWD; ctrl.alusrc = 1'b1;
                ctrl.mrd = 1'b1; ctrl.memtoreg = 1'b1;
            end
            OP_SWD:   begin ctrl.aluop = ALU_FWD; ctrl.mwr = 1'b1; end
            OP_SWI:   begin ctrl.aluop = ALU_FWD; ctrl.alusrc = 1'b1; ctrl.mwr = 1'b1; end
            default:  ctrl = '0;
        endcase
    end

    // Two's-complement negation turns the adder into a subtractor for sub/beq.
    assign opb   = ctrl.neg ? (~REGOUT2 + 8'd1) : REGOUT2;
    assign alu_b = ctrl.alusrc ? imm : opb;

    cpu_exec_alu u_alu (
        .a      (REGOUT1),
        .b      (alu_b),
        .sel    (ctrl.aluop),
        .result (ALURESULT),
        .zero   (ZERO)
    );

    // j has NEG low so it is always taken; beq (NEG high) needs ZERO.
    assign pc4     = PC + 32'd4;
    assign target  = pc4 + {{22{offset[7]}}, offset, 2'b00};
    assign taken   = ctrl.branch & (~ctrl.neg | ZERO);
    assign next_pc = taken ? target : pc4;

    // PC register; reset overrides a pending stall.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            PC <= PC_RESET;
        end else if (!BUSYWAIT) begin
            PC <= next_pc;
        end
    end

    // No memory traffic before the first real fetch has happened.
    assign pc_valid  = ~RESET & (PC != PC_RESET);
    assign MEMREAD   = ctrl.mrd & pc_valid;
    assign MEMWRITE  = ctrl.mwr & pc_valid;

    assign REGWRITE  = ctrl.we & ~BUSYWAIT & ~RESET;
    assign WRITEBACK = ctrl.memtoreg ? READDATA : ALURESULT;

endmodule

// File: tb/tb_cpu_exec_core.sv
// ---------------------------------------------------------------------------
// tb_cpu_exec_core
// Self-checking bench for cpu_exec_core. Directed scenarios follow the core's
// intended behaviour; a randomized phase compares against a behavioural model
// that computes results from the instruction semantics with plain arithmetic.
// ---------------------------------------------------------------------------
module tb_cpu_exec_core;

    localparam logic [31:0] RST_PC = 32'hFFFF_FFFC;
    localparam logic [31:0] NOP    = 32'hFF00_0000;

    logic        CLK;
    logic        RESET;
    logic        BUSYWAIT;
    logic [31:0] INSTRUCTION;
    logic [7:0]  REGOUT1;
    logic [7:0]  REGOUT2;
    logic [7:0]  READDATA;
    logic [31:0] PC;
    logic [2:0]  READREG1;
    logic [2:0]  READREG2;
    logic [2:0]  WRITEREG;
    logic        REGWRITE;
    logic [7:0]  WRITEBACK;
    logic [7:0]  ALURESULT;
    logic [7:0]  WRITEDATA;
    logic        MEMREAD;
    logic        MEMWRITE;
    logic        ZERO;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_pc;

    cpu_exec_core dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .BUSYWAIT    (BUSYWAIT),
        .INSTRUCTION (INSTRUCTION),
        .REGOUT1     (REGOUT1),
        .REGOUT2     (REGOUT2),
        .READDATA    (READDATA),
        .PC          (PC),
        .READREG1    (READREG1),
        .READREG2    (READREG2),
        .WRITEREG    (WRITEREG),
        .REGWRITE    (REGWRITE),
        .WRITEBACK   (WRITEBACK),
        .ALURESULT   (ALURESULT),
        .WRITEDATA   (WRITEDATA),
        .MEMREAD     (MEMREAD),
        .MEMWRITE    (MEMWRITE),
        .ZERO        (ZERO)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [7:0]  res;
        logic        regwrite;
        logic [7:0]  writeback;
        logic        memread;
        logic        memwrite;
        logic        zero;
        logic [31:0] next_pc;
    } exp_t;

    // Instruction-level reference: what each opcode means, not how it is built.
    function automatic exp_t model(input logic [31:0] instr, input logic [7:0] r1,
                                   input logic [7:0] r2, input logic [7:0] rd,
                                   input logic busy, input logic rst,
                                   input logic [31:0] pc);
        exp_t e;
        int   op, off, diff;
        bit   writes, loads, stores, jump;
        op = int'(instr[31:24]);
        off = int'($signed(instr[23:16]));
        diff = int'(r1) - int'(r2);
        writes = 0; loads = 0; stores = 0; jump = 0;
        e = '0;
        case (op)
            0:  begin e.res = instr[7:0]; writes = 1; end
            1:  begin e.res = r2; writes = 1; end
            2:  begin e.res = 8'((int'(r1) + int'(r2)) % 256); writes = 1; end
            3:  begin e.res = 8'(diff & 255); writes = 1; end
            4:  begin e.res = r1 & r2; writes = 1; end
            5:  begin e.res = r1 | r2; writes = 1; end
            6:  begin e.res = r2; jump = 1; end
            7:  begin e.res = 8'(diff & 255); jump = (r1 == r2); end
            8:  begin e.res = r2; writes = 1; loads = 1; end
            9:  begin e.res = instr[7:0]; writes = 1; loads = 1; end
            10: begin e.res = r2; stores = 1; end
            11: begin e.res = instr[7:0]; stores = 1; end
            default: e.res = r2;
        endcase
        e.zero      = (e.res == 8'd0);
        e.regwrite  = writes && !busy && !rst;
        e.writeback = loads ? rd : e.res;
        e.memread   = loads && !rst && (pc != RST_PC);
        e.memwrite  = stores && !rst && (pc != RST_PC);
        if (rst)       e.next_pc = RST_PC;
        else if (busy) e.next_pc = pc;
        else if (jump) e.next_pc = pc + 32'd4 + 32'(off * 4);
        else           e.next_pc = pc + 32'd4;
        return e;
    endfunction

    task automatic drive(input logic [31:0] instr, input logic [7:0] r1,
                         input logic [7:0] r2, input logic [7:0] rd, input logic busy);
        INSTRUCTION = instr;
        REGOUT1     = r1;
        REGOUT2     = r2;
        READDATA    = rd;
        BUSYWAIT    = busy;
    endtask

    task automatic restart();
        @(negedge CLK);
        RESET = 1'b1;
        drive(NOP, 8'h00, 8'h00, 8'h00, 1'b0);
        @(negedge CLK);
        RESET = 1'b0;
        @(posedge CLK); #1;
        exp_pc = 32'h0;
        checks++; if (PC !== exp_pc) begin errors++; $display("[TB] FAIL restart_pc got=%h want=%h", PC, exp_pc); end
    endtask

    task automatic advance(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            drive(NOP, 8'h00, 8'h00, 8'h00, 1'b0);
            @(posedge CLK); #1;
            exp_pc = exp_pc + 32'd4;
            checks++; if (PC !== exp_pc) begin errors++; $display("[TB] FAIL advance_pc got=%h want=%h", PC, exp_pc); end
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        drive(32'h0800_0001, 8'h11, 8'h22, 8'h33, 1'b0);
        #3;
        checks++; if (PC !== RST_PC) begin errors++; $display("[TB] FAIL reset_pc got=%h want=%h", PC, RST_PC); end
        checks++; if (MEMREAD !== 1'b0) begin errors++; $display("[TB] FAIL reset_memread got=%b want=0", MEMREAD); end
        checks++; if (REGWRITE !== 1'b0) begin errors++; $display("[TB] FAIL reset_regwrite got=%b want=0", REGWRITE); end
        @(negedge CLK);
        RESET = 1'b0;
        #1;
        // Reset released but no fetch yet: load must not reach memory.
        checks++; if (MEMREAD !== 1'b0) begin errors++; $display("[TB] FAIL prefetch_memread got=%b want=0", MEMREAD); end
        drive(NOP, 8'h00, 8'h00, 8'h00, 1'b0);
        @(posedge CLK); #1;
        checks++; if (PC !== 32'h0) begin errors++; $display("[TB] FAIL first_fetch_pc got=%h want=00000000", PC); end
        @(posedge CLK); #1;
        checks++; if (PC !== 32'h4) begin errors++; $display("[TB] FAIL second_fetch_pc got=%h want=00000004", PC); end
        drive(32'h0A00_0102, 8'hAB, 8'h40, 8'h00, 1'b0);
        #2;
        RESET = 1'b1;
        #1;
        checks++; if (PC !== RST_PC) begin errors++; $display("[TB] FAIL midcycle_reset_pc got=%h want=%h", PC, RST_PC); end
        checks++; if (MEMWRITE !== 1'b0) begin errors++; $display("[TB] FAIL midcycle_reset_memwrite got=%b want=0", MEMWRITE); end
        restart();
    endtask

    task automatic test_alu_ops();
        logic [31:0] instr [5] = '{32'h0005_0005, 32'h0201_0102, 32'h0302_0304, 32'h0403_0506, 32'h0504_0506};
        logic [7:0]  r1    [5] = '{8'h00, 8'hF0, 8'h07, 8'h0F, 8'h0F};
        logic [7:0]  r2    [5] = '{8'h00, 8'h20, 8'h07, 8'h3C, 8'h3C};
        logic [7:0]  want  [5] = '{8'h05, 8'h10, 8'h00, 8'h0C, 8'h3F};
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            drive(instr[i], r1[i], r2[i], 8'h99, 1'b0);
            #1;
            e = model(instr[i], r1[i], r2[i], 8'h99, 1'b0, 1'b0, exp_pc);
            checks++; if (ALURESULT !== want[i]) begin errors++; $display("[TB] FAIL alu_result[%0d] got=%h want=%h", i, ALURESULT, want[i]); end
            checks++; if (REGWRITE !== 1'b1) begin errors++; $display("[TB] FAIL alu_regwrite[%0d] got=%b want=1", i, REGWRITE); end
            checks++; if (ZERO !== (want[i] == 8'h00)) begin errors++; $display("[TB] FAIL alu_zero[%0d] got=%b want=%b", i, ZERO, want[i] == 8'h00); end
            checks++; if (WRITEBACK !== e.writeback) begin errors++; $display("[TB] FAIL alu_writeback[%0d] got=%h want=%h", i, WRITEBACK, e.writeback); end
            @(posedge CLK); #1;
            exp_pc = exp_pc + 32'd4;
            checks++; if (PC !== exp_pc) begin errors++; $display("[TB] FAIL alu_pc[%0d] got=%h want=%h", i, PC, exp_pc); end
        end
    endtask

    task automatic test_branches();
        logic [31:0] instr [6] = '{32'h06FE_0000, NOP, 32'h0702_0102, 32'h06FC_0000, 32'h0702_0102, 32'h0780_0102};
        logic [7:0]  r1    [6] = '{8'h00, 8'h00, 8'h33, 8'h00, 8'h33, 8'h05};
        logic [7:0]  r2    [6] = '{8'h00, 8'h00, 8'h33, 8'h00, 8'h34, 8'h05};
        logic [31:0] want  [6] = '{32'h0C, 32'h10, 32'h1C, 32'h10, 32'h14, 32'hFFFF_FE18};
        restart();
        advance(4);
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            drive(instr[i], r1[i], r2[i], 8'h00, 1'b0);
            #1;
            checks++; if (REGWRITE !== 1'b0) begin errors++; $display("[TB] FAIL branch_regwrite[%0d] got=%b want=0", i, REGWRITE); end
            @(posedge CLK); #1;
            exp_pc = want[i];
            checks++; if (PC !== want[i]) begin errors++; $display("[TB] FAIL branch_pc[%0d] got=%h want=%h", i, PC, want[i]); end
        end
        // Forward jump from the top of the address space wraps to low memory.
        @(negedge CLK);
        drive(32'h067F_0000, 8'h00, 8'h00, 8'h00, 1'b0);
        @(posedge CLK); #1;
        exp_pc = 32'h18;
        checks++; if (PC !== 32'h18) begin errors++; $display("[TB] FAIL branch_wrap_pc got=%h want=00000018", PC); end
    endtask

    task automatic test_load_stall();
        restart();
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            drive(32'h0901_0022, 8'h00, 8'h00, 8'h5A, 1'b1);
            #1;
            checks++; if (MEMREAD !== 1'b1) begin errors++; $display("[TB] FAIL stall_memread[%0d] got=%b want=1", i, MEMREAD); end
            checks++; if (ALURESULT !== 8'h22) begin errors++; $display("[TB] FAIL stall_addr[%0d] got=%h want=22", i, ALURESULT); end
            checks++; if (REGWRITE !== 1'b0) begin errors++; $display("[TB] FAIL stall_regwrite[%0d] got=%b want=0", i, REGWRITE); end
            @(posedge CLK); #1;
            checks++; if (PC !== exp_pc) begin errors++; $display("[TB] FAIL stall_pc[%0d] got=%h want=%h", i, PC, exp_pc); end
        end
        @(negedge CLK);
        BUSYWAIT = 1'b0;
        #1;
        checks++; if (REGWRITE !== 1'b1) begin errors++; $display("[TB] FAIL load_regwrite got=%b want=1", REGWRITE); end
        checks++; if (WRITEBACK !== 8'h5A) begin errors++; $display("[TB] FAIL load_writeback got=%h want=5a", WRITEBACK); end
        @(posedge CLK); #1;
        exp_pc = exp_pc + 32'd4;
        checks++; if (PC !== exp_pc) begin errors++; $display("[TB] FAIL load_pc got=%h want=%h", PC, exp_pc); end
    endtask

    task automatic test_reset_mid_stall();
        @(negedge CLK);
        drive(32'h0901_0022, 8'h00, 8'h00, 8'h5A, 1'b1);
        @(posedge CLK); #2;
        RESET = 1'b1;
        #1;
        checks++; if (PC !== RST_PC) begin errors++; $display("[TB] FAIL stall_reset_pc got=%h want=%h", PC, RST_PC); end
        checks++; if (MEMREAD !== 1'b0) begin errors++; $display("[TB] FAIL stall_reset_memread got=%b want=0", MEMREAD); end
        BUSYWAIT = 1'b0;
        #1;
        checks++; if (REGWRITE !== 1'b0) begin errors++; $display("[TB] FAIL reset_wins_regwrite got=%b want=0", REGWRITE); end
        BUSYWAIT = 1'b1;
        @(posedge CLK); #1;
        checks++; if (PC !== RST_PC) begin errors++; $display("[TB] FAIL reset_held_pc got=%h want=%h", PC, RST_PC); end
        restart();
    endtask

    task automatic test_store_and_nop();
        @(negedge CLK);
        drive(32'h0A00_0102, 8'hAB, 8'h40, 8'h00, 1'b0);
        #1;
        checks++; if (MEMWRITE !== 1'b1) begin errors++; $display("[TB] FAIL store_memwrite got=%b want=1", MEMWRITE); end
        checks++; if (MEMREAD !== 1'b0) begin errors++; $display("[TB] FAIL store_memread got=%b want=0", MEMREAD); end
        checks++; if (ALURESULT !== 8'h40) begin errors++; $display("[TB] FAIL store_addr got=%h want=40", ALURESULT); end
        checks++; if (WRITEDATA !== 8'hAB) begin errors++; $display("[TB] FAIL store_data got=%h want=ab", WRITEDATA); end
        checks++; if (REGWRITE !== 1'b0) begin errors++; $display("[TB] FAIL store_regwrite got=%b want=0", REGWRITE); end
        @(posedge CLK); #1;
        exp_pc = exp_pc + 32'd4;
        checks++; if (PC !== exp_pc) begin errors++; $display("[TB] FAIL store_pc got=%h want=%h", PC, exp_pc); end
        @(negedge CLK);
        drive(32'hFFFF_FFFF, 8'h12, 8'h34, 8'h56, 1'b0);
        #1;
        checks++; if ({REGWRITE, MEMREAD, MEMWRITE} !== 3'b000) begin errors++; $display("[TB] FAIL illegal_ctrl got=%b want=000", {REGWRITE, MEMREAD, MEMWRITE}); end
        @(posedge CLK); #1;
        exp_pc = exp_pc + 32'd4;
        checks++; if (PC !== exp_pc) begin errors++; $display("[TB] FAIL illegal_pc got=%h want=%h", PC, exp_pc); end
    endtask

    task automatic test_random();
        logic [31:0] instr;
        logic [7:0]  r1, r2, rd;
        logic        busy;
        exp_t        e;
        for (int i = 0; i < 300; i++) begin
            @(negedge CLK);
            instr = $urandom;
            if ($urandom_range(0, 7) != 0) instr[31:24] = 8'($urandom_range(0, 11));
            r1 = 8'($urandom);
            r2 = ($urandom_range(0, 3) == 0) ? r1 : 8'($urandom);
            rd = 8'($urandom);
            busy = ($urandom_range(0, 3) == 0);
            drive(instr, r1, r2, rd, busy);
            #1;
            e = model(instr, r1, r2, rd, busy, 1'b0, exp_pc);
            checks++; if (ALURESULT !== e.res) begin errors++; $display("[TB] FAIL rnd_result[%0d] instr=%h got=%h want=%h", i, instr, ALURESULT, e.res); end
            checks++; if (ZERO !== e.zero) begin errors++; $display("[TB] FAIL rnd_zero[%0d] instr=%h got=%b want=%b", i, instr, ZERO, e.zero); end
            checks++; if (REGWRITE !== e.regwrite) begin errors++; $display("[TB] FAIL rnd_regwrite[%0d] instr=%h got=%b want=%b", i, instr, REGWRITE, e.regwrite); end
            checks++; if (WRITEBACK !== e.writeback) begin errors++; $display("[TB] FAIL rnd_writeback[%0d] instr=%h got=%h want=%h", i, instr, WRITEBACK, e.writeback); end
            checks++; if ({MEMREAD, MEMWRITE} !== {e.memread, e.memwrite}) begin errors++; $display("[TB] FAIL rnd_mem[%0d] instr=%h got=%b want=%b", i, instr, {MEMREAD, MEMWRITE}, {e.memread, e.memwrite}); end
            checks++; if (WRITEDATA !== r1) begin errors++; $display("[TB] FAIL rnd_writedata[%0d] got=%h want=%h", i, WRITEDATA, r1); end
            checks++; if ({READREG1, READREG2, WRITEREG} !== {instr[10:8], instr[2:0], instr[18:16]}) begin
                errors++; $display("[TB] FAIL rnd_regaddr[%0d] got=%h want=%h", i, {READREG1, READREG2, WRITEREG}, {instr[10:8], instr[2:0], instr[18:16]});
            end
            @(posedge CLK); #1;
            exp_pc = e.next_pc;
            checks++; if (PC !== exp_pc) begin errors++; $display("[TB] FAIL rnd_pc[%0d] instr=%h got=%h want=%h", i, instr, PC, exp_pc); end
        end
    endtask

    initial begin
        exp_pc = RST_PC;
        test_reset();
        test_alu_ops();
        test_branches();
        test_load_stall();
        test_reset_mid_stall();
        test_store_and_nop();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
